// File: rtl/bram_rr_arbiter.sv
// ---------------------------------------------------------------------------
// bram_rr_arbiter
//   Round-robin arbiter that shares one BRAM port between NUM_REQ requesters.
//   A requester holds req high for its whole transaction; while it owns the
//   port its address / write data / byte enables are muxed onto the BRAM.
//   When the owner releases req, the arbiter drains for RD_LAT cycles so that
//   every outstanding read returns its rd_valid before the next owner starts.
//
//   Optional feature: define ARB_TIMEOUT_EN to bound each grant to MAX_HOLD
//   cycles. An expired grant is revoked with a one-cycle timeout pulse.
//
// Ports
//   aclk, aresetn          clock, asynchronous active-low reset
//   req        [NUM_REQ]   per-requester level request
//   gnt        [NUM_REQ]   registered one-hot grant
//   req_addr   [NUM_REQ*32] per-requester byte address
//   req_wrdata [NUM_REQ*32] per-requester write data
//   req_we     [NUM_REQ*4]  per-requester byte write enables
//   rd_data    [32]        BRAM read data broadcast to all requesters
//   rd_valid   [NUM_REQ]   one-hot qualifier for rd_data
//   BRAM_ADDR/BRAM_WRDATA/BRAM_WE  shared BRAM port
//   BRAM_RDDATA [32]       BRAM read data
//   busy                   arbiter is not idle
//   timeout                one-cycle pulse on a forced grant revoke
// ---------------------------------------------------------------------------
module bram_rr_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int RD_LAT   = 2,
    parameter int MAX_HOLD = 256
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic [NUM_REQ-1:0]      req,
    output logic [NUM_REQ-1:0]      gnt,
    input  logic [NUM_REQ*32-1:0]   req_addr,
    input  logic [NUM_REQ*32-1:0]   req_wrdata,
    input  logic [NUM_REQ*4-1:0]    req_we,
    output logic [31:0]             rd_data,
    output logic [NUM_REQ-1:0]      rd_valid,
    output logic [31:0]             BRAM_ADDR,
    output logic [31:0]             BRAM_WRDATA,
    output logic [3:0]              BRAM_WE,
    input  logic [31:0]             BRAM_RDDATA,
    output logic                    busy,
    output logic                    timeout
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(RD_LAT + 1);

    if (NUM_REQ < 2 || NUM_REQ > 8 || RD_LAT < 1 || RD_LAT > 4 || MAX_HOLD < 1) begin : g_param_err
        $error("bram_rr_arbiter: parameter out of range");
    end

    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_DRAIN} state_t;

    state_t             r_state;
    logic [IDX_W-1:0]   r_owner;
    logic [IDX_W-1:0]   r_ptr;
    logic [NUM_REQ-1:0] r_gnt;
    logic [CNT_W-1:0]   r_drain_cnt;
    logic [RD_LAT-1:0]  r_rd_vld;
    logic [IDX_W-1:0]   r_rd_idx [RD_LAT];

    logic               w_found;
    logic [IDX_W-1:0]   w_next_owner;
    logic [NUM_REQ-1:0] w_next_gnt;
    logic               w_own_req;
    logic [31:0]        w_own_addr;
    logic [31:0]        w_own_wrdata;
    logic [3:0]         w_own_we;
    logic               w_access;
    logic               w_rd_access;
    logic               w_expire;
    logic               w_drop;

    // Round-robin pick: first requester above ptr, then wrap to the lowest
    // index at or below ptr, so the previous owner is considered last.
    always_comb begin
        w_found      = 1'b0;
        w_next_owner = '0;
        w_next_gnt   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_found && req[i] && (IDX_W'(i) > r_ptr)) begin
                w_found       = 1'b1;
                w_next_owner  = IDX_W'(i);
                w_next_gnt[i] = 1'b1;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_found && req[i] && (IDX_W'(i) <= r_ptr)) begin
                w_found       = 1'b1;
                w_next_owner  = IDX_W'(i);
                w_next_gnt[i] = 1'b1;
            end
        end
    end

    // Owner slice mux
    always_comb begin
        w_own_req    = 1'b0;
        w_own_addr   = '0;
        w_own_wrdata = '0;
        w_own_we     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_owner == IDX_W'(i)) begin
                w_own_req    = req[i];
                w_own_addr   = req_addr[i*32 +: 32];
                w_own_wrdata = req_wrdata[i*32 +: 32];
                w_own_we     = req_we[i*4 +: 4];
            end
        end
    end

    // The cycle in which the owner releases req is not an access: the port
    // is already quiet while the grant is being revoked.
    assign w_access    = (r_state == S_GRANT) && w_own_req;
    assign w_rd_access = w_access && (w_own_we == 4'b0);
    assign w_drop      = (r_state == S_GRANT) && (!w_own_req || w_expire);

    assign BRAM_ADDR   = w_access ? w_own_addr   : 32'h0;
    assign BRAM_WRDATA = w_access ? w_own_wrdata : 32'h0;
    assign BRAM_WE     = w_access ? w_own_we     : 4'h0;

`ifdef ARB_TIMEOUT_EN
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);

    logic [HOLD_W-1:0] r_hold;
    logic              r_timeout;

    // Expire on the last allowed granted cycle so the grant lasts exactly
    // MAX_HOLD cycles including that one.
    assign w_expire = (r_state == S_GRANT) && w_own_req && (r_hold == HOLD_W'(MAX_HOLD - 1));

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_hold    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_expire;
            if (r_state == S_IDLE) begin
                r_hold <= '0;
            end else if ((r_state == S_GRANT) && !w_expire) begin
                r_hold <= r_hold + 1'b1;
            end
        end
    end

    assign timeout = r_timeout;
`else
    assign w_expire = 1'b0;
    assign timeout  = 1'b0;
`endif

    // Arbitration FSM and read-return pipeline
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state     <= S_IDLE;
            r_owner     <= '0;
            r_ptr       <= IDX_W'(NUM_REQ - 1);
            r_gnt       <= '0;
            r_drain_cnt <= '0;
            r_rd_vld    <= '0;
            for (int s = 0; s < RD_LAT; s++) begin
                r_rd_idx[s] <= '0;
            end
        end else begin
            r_rd_vld[0] <= w_rd_access;
            r_rd_idx[0] <= r_owner;
            for (int s = 1; s < RD_LAT; s++) begin
                r_rd_vld[s] <= r_rd_vld[s-1];
                r_rd_idx[s] <= r_rd_idx[s-1];
            end

            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_owner <= w_next_owner;
                        r_gnt   <= w_next_gnt;
                        r_state <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    if (w_drop) begin
                        r_gnt       <= '0;
                        r_drain_cnt <= CNT_W'(RD_LAT);
                        r_state     <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (r_drain_cnt <= CNT_W'(1)) begin
                        r_drain_cnt <= '0;
                        r_ptr       <= r_owner;
                        r_state     <= S_IDLE;
                    end else begin
                        r_drain_cnt <= r_drain_cnt - 1'b1;
                    end
                end
                default: begin
                    r_gnt   <= '0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        rd_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rd_valid[i] = r_rd_vld[RD_LAT-1] && (r_rd_idx[RD_LAT-1] == IDX_W'(i));
        end
    end

    assign gnt     = r_gnt;
    assign busy    = (r_state != S_IDLE);
    assign rd_data = BRAM_RDDATA;

endmodule

// File: tb/tb_bram_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bram_rr_arbiter
//   Directed testbench for bram_rr_arbiter (NUM_REQ=4, RD_LAT=2, MAX_HOLD=8).
//   Inputs change 1 ns after the rising edge; outputs are sampled there too.
// ---------------------------------------------------------------------------
module tb_bram_rr_arbiter;

    logic         aclk;
    logic         aresetn;
    logic [3:0]   req;
    logic [3:0]   gnt;
    logic [127:0] req_addr;
    logic [127:0] req_wrdata;
    logic [15:0]  req_we;
    logic [31:0]  rd_data;
    logic [3:0]   rd_valid;
    logic [31:0]  BRAM_ADDR;
    logic [31:0]  BRAM_WRDATA;
    logic [3:0]   BRAM_WE;
    logic [31:0]  BRAM_RDDATA;
    logic         busy;
    logic         timeout;

    int total = 0;
    int bad   = 0;

    bram_rr_arbiter #(
        .NUM_REQ (4),
        .RD_LAT  (2),
        .MAX_HOLD(8)
    ) dut (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .req        (req),
        .gnt        (gnt),
        .req_addr   (req_addr),
        .req_wrdata (req_wrdata),
        .req_we     (req_we),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .BRAM_ADDR  (BRAM_ADDR),
        .BRAM_WRDATA(BRAM_WRDATA),
        .BRAM_WE    (BRAM_WE),
        .BRAM_RDDATA(BRAM_RDDATA),
        .busy       (busy),
        .timeout    (timeout)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic do_reset();
        aresetn     = 1'b0;
        req         = '0;
        req_addr    = '0;
        req_wrdata  = '0;
        req_we      = '0;
        BRAM_RDDATA = '0;
        tick();
        aresetn = 1'b1;
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        req     = 4'b1111;
        tick();
        tick();
        total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
        total++; if (rd_valid !== 4'b0000) begin bad++; $display("FAIL reset_rd_valid: got %b want 0000", rd_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (timeout !== 1'b0) begin bad++; $display("FAIL reset_timeout: got %b want 0", timeout); end
        total++; if (BRAM_ADDR !== 32'h0 || BRAM_WE !== 4'h0) begin bad++; $display("FAIL reset_port: got addr %h we %h want 0 0", BRAM_ADDR, BRAM_WE); end
        aresetn = 1'b1;
        tick();
        // ptr resets to NUM_REQ-1, so requester 0 wins the first arbitration
        total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL reset_first_prio: got %b want 0001", gnt); end
        req = '0;
    endtask

    task automatic test_single_read();
        do_reset();
        req_addr[31:0] = 32'h10;
        req_we[3:0]    = 4'h0;
        BRAM_RDDATA    = 32'hCAFEF00D;
        req            = 4'b0001;
        #1;
        total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL sr_pre_gnt: got %b want 0000", gnt); end
        tick();
        total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL sr_gnt: got %b want 0001", gnt); end
        total++; if (BRAM_ADDR !== 32'h10) begin bad++; $display("FAIL sr_addr: got %h want 00000010", BRAM_ADDR); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL sr_busy: got %b want 1", busy); end
        total++; if (rd_data !== 32'hCAFEF00D) begin bad++; $display("FAIL sr_rd_data: got %h want cafef00d", rd_data); end
        tick();
        total++; if (rd_valid !== 4'b0000) begin bad++; $display("FAIL sr_rdv_early: got %b want 0000", rd_valid); end
        tick();
        total++; if (rd_valid !== 4'b0001) begin bad++; $display("FAIL sr_rdv_lat: got %b want 0001", rd_valid); end
        req = 4'b0000;
        #1;
        total++; if (BRAM_ADDR !== 32'h0) begin bad++; $display("FAIL sr_drop_addr: got %h want 0", BRAM_ADDR); end
        tick();
        total++; if (gnt !== 4'b0000 || busy !== 1'b1) begin bad++; $display("FAIL sr_drain1: got gnt %b busy %b want 0000 1", gnt, busy); end
        total++; if (rd_valid !== 4'b0001) begin bad++; $display("FAIL sr_rdv_drain: got %b want 0001", rd_valid); end
        tick();
        total++; if (rd_valid !== 4'b0000 || busy !== 1'b1) begin bad++; $display("FAIL sr_drain2: got rdv %b busy %b want 0000 1", rd_valid, busy); end
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL sr_idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_round_robin();
        int         exp_order [5];
        logic [3:0] exp_gnt;
        exp_order = '{0, 1, 2, 3, 0};
        do_reset();
        for (int i = 0; i < 4; i++) req_addr[i*32 +: 32] = 32'h100 * (i + 1);
        req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            exp_gnt = 4'b0001 << exp_order[n];
            tick();
            total++; if (gnt !== exp_gnt) begin bad++; $display("FAIL rr_gnt[%0d]: got %b want %b", n, gnt, exp_gnt); end
            total++; if (BRAM_ADDR !== 32'h100 * (exp_order[n] + 1)) begin bad++; $display("FAIL rr_addr[%0d]: got %h want %h", n, BRAM_ADDR, 32'h100 * (exp_order[n] + 1)); end
            tick();
            total++; if (gnt !== exp_gnt) begin bad++; $display("FAIL rr_hold2[%0d]: got %b want %b", n, gnt, exp_gnt); end
            tick();
            total++; if (gnt !== exp_gnt) begin bad++; $display("FAIL rr_hold3[%0d]: got %b want %b", n, gnt, exp_gnt); end
            req[exp_order[n]] = 1'b0;
            tick();
            total++; if (gnt !== 4'b0000 || busy !== 1'b1) begin bad++; $display("FAIL rr_drain1[%0d]: got gnt %b busy %b want 0000 1", n, gnt, busy); end
            req[exp_order[n]] = 1'b1;
            tick();
            total++; if (gnt !== 4'b0000 || busy !== 1'b1) begin bad++; $display("FAIL rr_drain2[%0d]: got gnt %b busy %b want 0000 1", n, gnt, busy); end
            tick();
            total++; if (gnt !== 4'b0000 || busy !== 1'b0) begin bad++; $display("FAIL rr_idle[%0d]: got gnt %b busy %b want 0000 0", n, gnt, busy); end
        end
        req = '0;
    endtask

    task automatic test_write_isolation();
        do_reset();
        req_addr[2*32 +: 32]   = 32'h40;
        req_wrdata[2*32 +: 32] = 32'hDEADBEEF;
        req_we[2*4 +: 4]       = 4'hF;
        req_addr[1*32 +: 32]   = 32'h99;
        req_wrdata[1*32 +: 32] = 32'h11111111;
        req_we[1*4 +: 4]       = 4'h3;
        req = 4'b0100;
        tick();
        req[1] = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            total++; if (gnt !== 4'b0100) begin bad++; $display("FAIL wr_gnt[%0d]: got %b want 0100", k, gnt); end
            total++; if (BRAM_ADDR !== 32'h40 || BRAM_WRDATA !== 32'hDEADBEEF || BRAM_WE !== 4'hF) begin
                bad++; $display("FAIL wr_port[%0d]: got %h %h %h want 00000040 deadbeef f", k, BRAM_ADDR, BRAM_WRDATA, BRAM_WE);
            end
            total++; if (rd_valid !== 4'b0000) begin bad++; $display("FAIL wr_rdv[%0d]: got %b want 0000", k, rd_valid); end
            if (k < 2) tick();
        end
        req[2] = 1'b0;
        tick();
        total++; if (BRAM_ADDR !== 32'h0 || BRAM_WRDATA !== 32'h0 || BRAM_WE !== 4'h0 || gnt !== 4'b0000) begin
            bad++; $display("FAIL wr_drain_port: got %h %h %h gnt %b want 0 0 0 0000", BRAM_ADDR, BRAM_WRDATA, BRAM_WE, gnt);
        end
        tick();
        tick();
        total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL wr_idle_gnt: got %b want 0000", gnt); end
        tick();
        total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL wr_next_gnt: got %b want 0010", gnt); end
        total++; if (BRAM_ADDR !== 32'h99 || BRAM_WRDATA !== 32'h11111111 || BRAM_WE !== 4'h3) begin
            bad++; $display("FAIL wr_next_port: got %h %h %h want 00000099 11111111 3", BRAM_ADDR, BRAM_WRDATA, BRAM_WE);
        end
        req = '0;
    endtask

    task automatic test_handover();
        do_reset();
        req_addr[31:0]       = 32'h20;
        req_addr[3*32 +: 32] = 32'h30;
        req = 4'b0001;
        tick();
        total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL ho_gnt0: got %b want 0001", gnt); end
        tick();
        tick();
        total++; if (rd_valid !== 4'b0001) begin bad++; $display("FAIL ho_rdv0: got %b want 0001", rd_valid); end
        req = 4'b1000;
        #1;
        total++; if (BRAM_ADDR !== 32'h0) begin bad++; $display("FAIL ho_drop_addr: got %h want 0", BRAM_ADDR); end
        tick();
        total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL ho_drain_gnt: got %b want 0000", gnt); end
        total++; if (rd_valid !== 4'b0001) begin bad++; $display("FAIL ho_last_rdv: got %b want 0001", rd_valid); end
        tick();
        total++; if (gnt !== 4'b0000 || rd_valid !== 4'b0000) begin bad++; $display("FAIL ho_drain2: got gnt %b rdv %b want 0000 0000", gnt, rd_valid); end
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL ho_idle: got busy %b want 0", busy); end
        tick();
        total++; if (gnt !== 4'b1000) begin bad++; $display("FAIL ho_gnt3: got %b want 1000", gnt); end
        total++; if (BRAM_ADDR !== 32'h30) begin bad++; $display("FAIL ho_addr3: got %h want 00000030", BRAM_ADDR); end
        req = '0;
    endtask

    task automatic test_reset_abort();
        do_reset();
        req_addr[31:0] = 32'h50;
        req = 4'b0001;
        tick();
        tick();
        tick();
        total++; if (rd_valid !== 4'b0001) begin bad++; $display("FAIL ab_pre_rdv: got %b want 0001", rd_valid); end
        aresetn = 1'b0;
        req     = 4'b0000;
        #1;
        total++; if (gnt !== 4'b0000 || rd_valid !== 4'b0000 || busy !== 1'b0) begin
            bad++; $display("FAIL ab_immediate: got gnt %b rdv %b busy %b want 0000 0000 0", gnt, rd_valid, busy);
        end
        aresetn = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            total++; if (rd_valid !== 4'b0000 || gnt !== 4'b0000) begin
                bad++; $display("FAIL ab_after[%0d]: got rdv %b gnt %b want 0000 0000", k, rd_valid, gnt);
            end
        end
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        req = 4'b0011;
        for (int k = 0; k < 8; k++) begin
            tick();
            total++; if (gnt !== 4'b0001 || timeout !== 1'b0) begin
                bad++; $display("FAIL to_hold[%0d]: got gnt %b to %b want 0001 0", k, gnt, timeout);
            end
        end
        tick();
        total++; if (timeout !== 1'b1 || gnt !== 4'b0000 || busy !== 1'b1) begin
            bad++; $display("FAIL to_pulse: got to %b gnt %b busy %b want 1 0000 1", timeout, gnt, busy);
        end
        tick();
        total++; if (timeout !== 1'b0 || gnt !== 4'b0000) begin bad++; $display("FAIL to_drain2: got to %b gnt %b want 0 0000", timeout, gnt); end
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL to_idle: got busy %b want 0", busy); end
        tick();
        total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL to_next_gnt: got %b want 0010", gnt); end
        req = '0;
    endtask
`else
    task automatic test_timeout();
        do_reset();
        req = 4'b0011;
        for (int k = 0; k < 12; k++) begin
            tick();
            total++; if (gnt !== 4'b0001 || timeout !== 1'b0) begin
                bad++; $display("FAIL nto_hold[%0d]: got gnt %b to %b want 0001 0", k, gnt, timeout);
            end
        end
        req = '0;
    endtask
`endif

    initial begin
        aresetn     = 1'b0;
        req         = '0;
        req_addr    = '0;
        req_wrdata  = '0;
        req_we      = '0;
        BRAM_RDDATA = '0;
        test_reset();
        test_single_read();
        test_round_robin();
        test_write_isolation();
        test_handover();
        test_reset_abort();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
